// File: rtl/axi_lite_pkg.sv
// Shared encodings for the AXI4-Lite memory responder: response codes,
// channel FSM states, bus widths and the address window check.
package axi_lite_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  // Unsigned wrap-around makes addresses below base fail the compare as well.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] span);
    return (addr - base) < span;
  endfunction

endpackage

// File: rtl/axi_lite_mem_array.sv
// Simple dual-port byte-writable RAM: one write port with per-byte enables,
// one read port with a registered output that returns old data on collision.
module axi_lite_mem_array
  import axi_lite_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic [STRB_W-1:0] we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  // One 8-bit-wide array per byte lane so each lane maps onto its own
  // block-RAM write enable; the read is held while re is low.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
    logic [7:0] mem_lane [DEPTH];
    logic [7:0] rdata_reg;

    always_ff @(posedge clk) begin
      if (we[gi]) begin
        mem_lane[waddr] <= wdata[8*gi +: 8];
      end
      if (re) begin
        rdata_reg <= mem_lane[raddr];
      end
    end

    assign rdata[8*gi +: 8] = rdata_reg;
  end

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite responder in front of a byte-writable RAM window at BASE_ADDR.
// Independent read and write channels, one outstanding transaction each.
module axi_lite_mem_responder
  import axi_lite_pkg::*;
#(
  parameter int          MEM_DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR       = 32'h4000_0000,
  parameter int          IDX_W           = $clog2(MEM_DEPTH_WORDS)
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [31:0]       s0_awaddr,
  input  logic [2:0]        s0_awprot,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [STRB_W-1:0] s0_wstrb,
  output logic              s0_bvalid,
  input  logic              s0_bready,
  output logic [1:0]        s0_bresp,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [31:0]       s0_araddr,
  input  logic [2:0]        s0_arprot,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [1:0]        s0_rresp,
  output logic [DATA_W-1:0] s0_rdata
);

  localparam logic [31:0] SPAN_BYTES = 32'(MEM_DEPTH_WORDS * 4);

  wr_state_e         wr_state_reg, wr_state_next;
  logic [31:0]       aw_addr_reg, aw_addr_next;
  logic [DATA_W-1:0] w_data_reg, w_data_next;
  logic [STRB_W-1:0] w_strb_reg, w_strb_next;
  logic [1:0]        bresp_reg, bresp_next;

  logic              aw_hs, w_hs, wr_commit, commit_in_range;
  logic [31:0]       commit_addr, commit_offset;
  logic [DATA_W-1:0] commit_data;
  logic [STRB_W-1:0] commit_strb;
  logic [STRB_W-1:0] mem_we;
  logic [IDX_W-1:0]  mem_waddr;

  rd_state_e         rd_state_reg, rd_state_next;
  logic [1:0]        rresp_reg, rresp_next;
  logic              ar_hs;
  logic [31:0]       rd_offset;
  logic [IDX_W-1:0]  mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  // Readies depend only on state and reset, never on the valids.
  assign s0_awready = !g_reset && (wr_state_reg == W_IDLE || wr_state_reg == W_HAVE_W);
  assign s0_wready  = !g_reset && (wr_state_reg == W_IDLE || wr_state_reg == W_HAVE_AW);
  assign s0_arready = !g_reset && (rd_state_reg == R_IDLE);

  assign aw_hs = s0_awvalid && s0_awready;
  assign w_hs  = s0_wvalid && s0_wready;
  assign ar_hs = s0_arvalid && s0_arready;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wr_state_reg <= W_IDLE;
      aw_addr_reg  <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bresp_reg    <= RESP_OKAY;
    end else begin
      wr_state_reg <= wr_state_next;
      aw_addr_reg  <= aw_addr_next;
      w_data_reg   <= w_data_next;
      w_strb_reg   <= w_strb_next;
      bresp_reg    <= bresp_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    aw_addr_next  = aw_addr_reg;
    w_data_next   = w_data_reg;
    w_strb_next   = w_strb_reg;
    bresp_next    = bresp_reg;
    wr_commit     = 1'b0;
    commit_addr   = s0_awaddr;
    commit_data   = s0_wdata;
    commit_strb   = s0_wstrb;

    case (wr_state_reg)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit = 1'b1;
        end else if (aw_hs) begin
          aw_addr_next  = s0_awaddr;
          wr_state_next = W_HAVE_AW;
        end else if (w_hs) begin
          w_data_next   = s0_wdata;
          w_strb_next   = s0_wstrb;
          wr_state_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        commit_addr = aw_addr_reg;
        wr_commit   = w_hs;
      end
      W_HAVE_W: begin
        commit_data = w_data_reg;
        commit_strb = w_strb_reg;
        wr_commit   = aw_hs;
      end
      W_RESP: begin
        if (s0_bready) begin
          wr_state_next = W_IDLE;
        end
      end
      default: wr_state_next = W_IDLE;
    endcase

    commit_in_range = addr_in_range(commit_addr, BASE_ADDR, SPAN_BYTES);
    if (wr_commit) begin
      wr_state_next = W_RESP;
      bresp_next    = commit_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign commit_offset = commit_addr - BASE_ADDR;
  assign mem_waddr     = commit_offset[IDX_W+1:2];
  // Out-of-range writes still complete on the bus but never touch the RAM.
  assign mem_we        = (wr_commit && commit_in_range) ? commit_strb : '0;

  assign s0_bvalid = (wr_state_reg == W_RESP);
  assign s0_bresp  = bresp_reg;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rd_state_reg <= R_IDLE;
      rresp_reg    <= RESP_OKAY;
    end else begin
      rd_state_reg <= rd_state_next;
      rresp_reg    <= rresp_next;
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    rresp_next    = rresp_reg;
    case (rd_state_reg)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_next = R_RESP;
          rresp_next    = addr_in_range(s0_araddr, BASE_ADDR, SPAN_BYTES) ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_RESP: begin
        if (s0_rready) begin
          rd_state_next = R_IDLE;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  assign rd_offset = s0_araddr - BASE_ADDR;
  assign mem_raddr = rd_offset[IDX_W+1:2];

  // The RAM output register only loads on an AR handshake, so it already
  // holds rdata stable for the whole R phase; masking gives zero on error
  // and out of reset without a second data register.
  assign s0_rvalid = (rd_state_reg == R_RESP);
  assign s0_rresp  = rresp_reg;
  assign s0_rdata  = (s0_rvalid && rresp_reg == RESP_OKAY) ? mem_rdata : '0;

  axi_lite_mem_array #(
    .DEPTH (MEM_DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (g_clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (commit_data),
    .re    (ar_hs),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  logic unused_bits;
  assign unused_bits = ^{s0_awprot, s0_arprot,
                         commit_offset[1:0], commit_offset[31:IDX_W+2],
                         rd_offset[1:0], rd_offset[31:IDX_W+2]};

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Self-checking bench for axi_lite_mem_responder: directed scenarios followed
// by randomized traffic compared against a word-array reference model.
module tb_axi_lite_mem_responder;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int          WORDS = 256;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        s0_awvalid, s0_awready;
  logic [31:0] s0_awaddr;
  logic [2:0]  s0_awprot;
  logic        s0_wvalid, s0_wready;
  logic [31:0] s0_wdata;
  logic [3:0]  s0_wstrb;
  logic        s0_bvalid, s0_bready;
  logic [1:0]  s0_bresp;
  logic        s0_arvalid, s0_arready;
  logic [31:0] s0_araddr;
  logic [2:0]  s0_arprot;
  logic        s0_rvalid, s0_rready;
  logic [1:0]  s0_rresp;
  logic [31:0] s0_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] model_mem [WORDS];

  always #5 g_clk = ~g_clk;

  axi_lite_mem_responder #(
    .MEM_DEPTH_WORDS (WORDS),
    .BASE_ADDR       (BASE)
  ) dut (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .s0_awvalid (s0_awvalid),
    .s0_awready (s0_awready),
    .s0_awaddr  (s0_awaddr),
    .s0_awprot  (s0_awprot),
    .s0_wvalid  (s0_wvalid),
    .s0_wready  (s0_wready),
    .s0_wdata   (s0_wdata),
    .s0_wstrb   (s0_wstrb),
    .s0_bvalid  (s0_bvalid),
    .s0_bready  (s0_bready),
    .s0_bresp   (s0_bresp),
    .s0_arvalid (s0_arvalid),
    .s0_arready (s0_arready),
    .s0_araddr  (s0_araddr),
    .s0_arprot  (s0_arprot),
    .s0_rvalid  (s0_rvalid),
    .s0_rready  (s0_rready),
    .s0_rresp   (s0_rresp),
    .s0_rdata   (s0_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(WORDS * 4));
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_in_range(a) ? model_mem[model_idx(a)] : 32'h0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    return model_in_range(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (model_in_range(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[model_idx(a)][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Issues AW and W with independent start delays, then holds bready low for
  // b_hold cycles before completing the B handshake.
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_hold);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    logic [1:0] exp_resp;
    s0_awaddr = addr;
    s0_wdata  = data;
    s0_wstrb  = strb;
    exp_resp  = model_resp(addr);
    while (!(aw_done && w_done) && cyc < 40) begin
      s0_awvalid = !aw_done && (cyc >= aw_dly);
      s0_wvalid  = !w_done && (cyc >= w_dly);
      hs_aw = s0_awvalid && s0_awready;
      hs_w  = s0_wvalid && s0_wready;
      if (w_done && !aw_done) check_eq("wready_low_after_w", 32'(s0_wready), 0);
      if (aw_done && !w_done) check_eq("awready_low_after_aw", 32'(s0_awready), 0);
      @(posedge g_clk); #1;
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done  = 1;
      cyc++;
    end
    s0_awvalid = 1'b0;
    s0_wvalid  = 1'b0;
    check_eq("aw_w_accepted", 32'({aw_done, w_done}), 32'h3);
    model_write(addr, data, strb);
    check_eq("bvalid_next_cycle", 32'(s0_bvalid), 1);
    for (int i = 0; i < b_hold; i++) begin
      check_eq("bvalid_hold", 32'(s0_bvalid), 1);
      check_eq("bresp_hold", 32'(s0_bresp), 32'(exp_resp));
      check_eq("readies_low_in_b", 32'({s0_awready, s0_wready}), 0);
      @(posedge g_clk); #1;
    end
    s0_bready = 1'b1;
    check_eq("bresp", 32'(s0_bresp), 32'(exp_resp));
    @(posedge g_clk); #1;
    s0_bready = 1'b0;
    check_eq("awready_after_b", 32'(s0_awready), 1);
    $display("write addr=0x%08h data=0x%08h strb=0x%h bresp=%0d", addr, data, strb, exp_resp);
  endtask

  task automatic read_txn(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int r_hold);
    int cyc = 0;
    s0_araddr  = addr;
    s0_arvalid = 1'b1;
    while (!s0_arready && cyc < 20) begin
      @(posedge g_clk); #1;
      cyc++;
    end
    check_eq("arready_seen", 32'(s0_arready), 1);
    @(posedge g_clk); #1;
    s0_arvalid = 1'b0;
    check_eq("rvalid_next_cycle", 32'(s0_rvalid), 1);
    check_eq("rdata", s0_rdata, exp_data);
    check_eq("rresp", 32'(s0_rresp), 32'(exp_resp));
    for (int i = 0; i < r_hold; i++) begin
      @(posedge g_clk); #1;
      check_eq("rvalid_hold", 32'(s0_rvalid), 1);
      check_eq("rdata_hold", s0_rdata, exp_data);
      check_eq("arready_low_in_r", 32'(s0_arready), 0);
    end
    s0_rready = 1'b1;
    @(posedge g_clk); #1;
    s0_rready = 1'b0;
    check_eq("rvalid_cleared", 32'(s0_rvalid), 0);
    $display("read  addr=0x%08h data=0x%08h rresp=%0d", addr, s0_rdata, exp_resp);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    g_reset    = 1'b1;
    s0_awvalid = 1'b0; s0_awaddr = '0; s0_awprot = 3'b0;
    s0_wvalid  = 1'b0; s0_wdata  = '0; s0_wstrb  = '0;
    s0_bready  = 1'b0;
    s0_arvalid = 1'b0; s0_araddr = '0; s0_arprot = 3'b0;
    s0_rready  = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    check_eq("reset_readies", 32'({s0_awready, s0_wready, s0_arready}), 0);
    check_eq("reset_valids", 32'({s0_bvalid, s0_rvalid}), 0);
    check_eq("reset_resps", 32'({s0_bresp, s0_rresp}), 0);
    check_eq("reset_rdata", s0_rdata, 0);
    g_reset = 1'b0;
    @(posedge g_clk); #1;
    check_eq("post_reset_readies", 32'({s0_awready, s0_wready, s0_arready}), 32'h7);

    // Same-cycle AW+W, then read back.
    write_txn(32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    read_txn(32'h4000_0010, 32'hDEAD_BEEF, 2'b00, 0);

    // W leads AW by three cycles with a partial strobe.
    write_txn(32'h4000_0010, 32'h1122_3344, 4'h5, 3, 0, 0);
    read_txn(32'h4000_0010, 32'hDE22_BE44, 2'b00, 0);

    // AW leads W, plus an all-zero strobe leaving the word untouched.
    write_txn(32'h4000_0000, 32'h0BAD_F00D, 4'hF, 0, 2, 0);
    write_txn(32'h4000_0000, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
    read_txn(32'h4000_0000, 32'h0BAD_F00D, 2'b00, 0);

    // Out-of-range accesses; 0x400 would alias word 0 if decode wrapped.
    write_txn(32'h4000_0400, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    read_txn(32'h4000_0000, 32'h0BAD_F00D, 2'b00, 0);
    read_txn(32'h3FFF_FFFC, 32'h0, 2'b10, 0);

    // Back-pressure on B and R.
    write_txn(32'h4000_0014, 32'h0102_0304, 4'hF, 0, 0, 5);
    read_txn(32'h4000_0014, 32'h0102_0304, 2'b00, 4);

    // Read and write committing to the same word on the same edge.
    write_txn(32'h4000_0020, 32'h0, 4'hF, 0, 0, 0);
    fork
      write_txn(32'h4000_0020, 32'hAAAA_5555, 4'hF, 0, 0, 0);
      read_txn(32'h4000_0020, 32'h0, 2'b00, 0);
    join
    read_txn(32'h4000_0020, 32'hAAAA_5555, 2'b00, 0);

    // Fill every word so random reads compare against known contents.
    for (int i = 0; i < WORDS; i++)
      write_txn(BASE + 32'(i * 4), $urandom, 4'hF, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      a = BASE + 32'($urandom_range(0, WORDS * 4 - 1));
      if ($urandom_range(0, 7) == 0)
        a = $urandom_range(0, 1) ? (BASE + 32'(WORDS * 4) + 32'($urandom_range(0, 4095)))
                                 : (BASE - 32'($urandom_range(1, 4096)));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        write_txn(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        read_txn(a, model_read(a), model_resp(a), $urandom_range(0, 2));
      end
    end

    // Reset while a read response is stalled.
    write_txn(32'h4000_0030, 32'h1357_2468, 4'hF, 0, 0, 0);
    s0_araddr  = 32'h4000_0030;
    s0_arvalid = 1'b1;
    @(posedge g_clk); #1;
    s0_arvalid = 1'b0;
    check_eq("rvalid_before_reset", 32'(s0_rvalid), 1);
    g_reset = 1'b1;
    #1;
    check_eq("readies_in_reset", 32'({s0_awready, s0_wready, s0_arready}), 0);
    @(posedge g_clk); #1;
    check_eq("rvalid_dropped", 32'(s0_rvalid), 0);
    check_eq("rdata_cleared", s0_rdata, 0);
    check_eq("bvalid_in_reset", 32'(s0_bvalid), 0);
    @(posedge g_clk); #1;
    check_eq("readies_still_reset", 32'({s0_awready, s0_wready, s0_arready}), 0);
    g_reset = 1'b0;
    @(posedge g_clk); #1;
    read_txn(32'h4000_0030, 32'h1357_2468, 2'b00, 0);
    read_txn(32'h4000_0020, model_read(32'h4000_0020), 2'b00, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
